// File: rtl/serial_add_pkg.sv
// ============================================================================
// Module   : serial_add_pkg
// Purpose  : Shared constants for the bit-serial adder controller: FSM state
//            encoding and the default operand width.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_add_pkg;

    // FSM state encoding (explicit 2-bit width)
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    // Default operand / sum width
    localparam int SERIAL_ADD_WIDTH = 8;

endpackage : serial_add_pkg

`default_nettype wire

// File: rtl/serial_fa_cell.sv
// ============================================================================
// Module   : serial_fa_cell
// Purpose  : Combinational 1-bit full adder built from an active-low 3-to-8
//            decoder. Each output is the NAND of the active-low minterm lines
//            it covers, which is the OR of the corresponding minterms.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic [2:0] w_sel;
    logic [7:0] w_dec_n;

    assign w_sel = {a, b, ci};

    // Active-low decoder: line i is driven low when the inputs encode i
    generate
        for (genvar i = 0; i < 8; i++) begin : g_dec
            assign w_dec_n[i] = (w_sel != 3'(i));
        end
    endgenerate

    // Sum covers minterms with an odd number of ones
    assign s  = ~(w_dec_n[1] & w_dec_n[2] & w_dec_n[4] & w_dec_n[7]);

    // Carry covers minterms with two or more ones
    assign co = ~(w_dec_n[3] & w_dec_n[5] & w_dec_n[6] & w_dec_n[7]);

endmodule : serial_fa_cell

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// ============================================================================
// Module   : serial_add_ctrl
// Purpose  : Bit-serial adder controller. Accepts an operand pair over a
//            valid/ready handshake, adds one bit per clock (LSB first) through
//            a single shared full-adder cell, then presents the registered
//            sum and carry-out over a second valid/ready handshake.
//            Optional macro SERIAL_ADD_SUB_EN adds a 'sub' input that turns
//            the operation into a - b (co = 1 means no borrow).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             busy
);

    localparam int            CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Holds the WIDTH-1 lower result bits; the final bit comes straight from the cell
    logic [WIDTH-2:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             co_q, co_d;

    logic             w_fa_s;
    logic             w_fa_co;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_b_cap;
    logic             w_carry_cap;

    // Shared full-adder cell working on the current LSBs and the running carry
    serial_fa_cell u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q),
        .s  (w_fa_s),
        .co (w_fa_co)
    );

    assign w_accept = in_valid && (state_q == IDLE);
    assign w_last   = (cnt_q == CNT_LAST);

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction is a + ~b + 1; ci is ignored when sub is set
    assign w_b_cap     = sub ? ~b : b;
    assign w_carry_cap = sub ? 1'b1 : ci;
`else
    assign w_b_cap     = b;
    assign w_carry_cap = ci;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (w_last)   state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and status outputs, decoded from the state register only
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == RUN) || (state_q == DONE);
    end

    // Datapath next-value: capture on accept, shift one bit per RUN cycle
    always_comb begin
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        sum_d   = sum_q;
        co_d    = co_q;
        if (w_accept) begin
            a_sh_d  = a;
            b_sh_d  = w_b_cap;
            carry_d = w_carry_cap;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            carry_d = w_fa_co;
            cnt_d   = cnt_q + CNT_W'(1);
            res_d   = (WIDTH-1)'({w_fa_s, res_q} >> 1);
            if (w_last) begin
                sum_d = {w_fa_s, res_q};
                co_d  = w_fa_co;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
        end else begin
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
        end
    end

    assign sum = sum_q;
    assign co  = co_q;

endmodule : serial_add_ctrl

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// ============================================================================
// Module   : tb_serial_add_ctrl
// Purpose  : Directed self-checking bench for serial_add_ctrl (WIDTH = 8).
//            Subtraction vectors are exercised when SERIAL_ADD_SUB_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
`ifdef SERIAL_ADD_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands and return just after the acceptance edge
    task automatic accept(input logic [7:0] av, input logic [7:0] bv,
                          input logic civ, input logic subv);
        a        = av;
        b        = bv;
        ci       = civ;
        sub      = subv;
        in_valid = 1'b1;
        check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    // Count cycles after acceptance until out_valid, bounded
    task automatic wait_done(input string tag, output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Full operation with result checks and output handshake
    task automatic do_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic civ, input logic subv,
                         input logic [7:0] exp_sum, input logic exp_co,
                         input logic [7:0] prev_sum);
        int lat;
        accept(av, bv, civ, subv);
        check({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
        check({tag, "_sum_held_run"}, {24'd0, sum}, {24'd0, prev_sum});
        wait_done(tag, lat);
        check({tag, "_latency"}, lat, WIDTH);
        check({tag, "_sum"}, {24'd0, sum}, {24'd0, exp_sum});
        check({tag, "_co"}, {31'd0, co}, {31'd0, exp_co});
        check({tag, "_in_ready_done"}, {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_idle_after"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        ci        = 1'b0;
        sub       = 1'b0;

        // Reset state
        repeat (2) step();
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum",       {24'd0, sum},       32'd0);
        check("rst_co",        {31'd0, co},        32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        rst_n = 1'b1;
        step();

        // Basic addition and carry chains
        do_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 8'h00);
        do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 8'h96);
        do_op("add_ff_ff", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 8'h00);

        // Backpressure: hold DONE for 5 cycles while new operands are offered
        accept(8'h12, 8'h34, 1'b1, 1'b0);
        wait_done("bp", lat);
        check("bp_latency", lat, WIDTH);
        a        = 8'hAA;
        b        = 8'h55;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_sum",       {24'd0, sum},       32'h47);
            check("bp_co",        {31'd0, co},        32'd0);
            check("bp_in_ready",  {31'd0, in_ready},  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_release_idle", {30'd0, out_valid, in_ready}, 32'd1);
        do_op("after_bp", 8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, 8'h47);

        // Reset mid-RUN after 4 bits
        accept(8'hFF, 8'h01, 1'b0, 1'b0);
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready",  {31'd0, in_ready},  32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_sum",       {24'd0, sum},       32'd0);
        check("midrst_co",        {31'd0, co},        32'd0);
        check("midrst_busy",      {31'd0, busy},      32'd0);
        step();
        rst_n = 1'b1;
        lat = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid) lat++;
        end
        check("midrst_no_pulse", lat, 0);
        do_op("after_rst", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 8'h00);

`ifdef SERIAL_ADD_SUB_EN
        do_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 8'h02);
        do_op("sub_01_02", 8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0, 8'h0F);
        do_op("sub0_add",  8'h5A, 8'h3C, 1'b1, 1'b0, 8'h97, 1'b0, 8'hFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_serial_add_ctrl

`default_nettype wire
